// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the 8-bit CPU issue stage
//
// Purpose: FSM state encoding, opcode/register widths, the HALT opcode,
// the reset PC and instruction field extraction helpers.
// Ports: none (package).
package cpu_pkg;

  localparam int          NUM_REGS     = 4;
  localparam int          REG_IDX_W    = 2;
  localparam int          OPC_W        = 5;
  localparam logic [4:0]  HALT_OPCODE  = 5'b11111;
  localparam logic [7:0]  PC_RESET_VAL = 8'h00;

  // byte0 = {opcode[4:0], rd[1:0], imm}; byte1 = imm ? immediate : {rs[1:0], 6'bx}
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 3;
  localparam int RD_MSB  = 2;
  localparam int RD_LSB  = 1;
  localparam int IMM_BIT = 0;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_EX   = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [7:0] b0);
    return b0[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [REG_IDX_W-1:0] rd_of(input logic [7:0] b0);
    return b0[RD_MSB:RD_LSB];
  endfunction

  function automatic logic imm_of(input logic [7:0] b0);
    return b0[IMM_BIT];
  endfunction

  function automatic logic [REG_IDX_W-1:0] rs_of(input logic [7:0] b1);
    return b1[RS_MSB:RS_LSB];
  endfunction

endpackage

// File: rtl/reg_file_4x8.sv
// rtl/reg_file_4x8.sv - 4x8 general register file, 2 async read ports, 1 sync write port
//
// Purpose: operand storage for the issue controller.
// Ports:
//   clk, rst_n        clock, asynchronous active-low clear of all registers
//   raddr_a/rdata_a   combinational read port A
//   raddr_b/rdata_b   combinational read port B
//   we/waddr/wdata    synchronous write port
module reg_file_4x8
  import cpu_pkg::*;
#(
  parameter int NREGS = NUM_REGS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] raddr_a,
  output logic [7:0]           rdata_a,
  input  logic [REG_IDX_W-1:0] raddr_b,
  output logic [7:0]           rdata_b,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [7:0]           wdata
);

  logic [7:0] regs_q [NREGS];
  logic [7:0] regs_d [NREGS];

  // Reads see the stored value, so a same-cycle write is not forwarded.
  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/alu_issue_controller.sv
// rtl/alu_issue_controller.sv - fetch/issue/writeback sequencer in front of the 8-bit ALU
//
// Purpose: fetches 2-byte instructions over a req/ack memory port, issues
// them to a free-running ALU for one cycle and writes the result and flags back.
// Ports:
//   clk, rst_n, start                 clock, async active-low reset, run pulse
//   mem_req/mem_addr/mem_ack/mem_rdata program memory handshake
//   alu_select/alu_a/alu_b/alu_op_enable ALU drive (registered)
//   alu_out/alu_flag_zero/alu_flag_carry ALU result, valid the cycle after enable
//   pc, flag_z, flag_c, halted, busy   status
module alu_issue_controller
  import cpu_pkg::*;
#(
  parameter int         NREGS    = NUM_REGS,
  parameter logic [4:0] HALT_OP  = HALT_OPCODE,
  parameter logic [7:0] PC_RESET = PC_RESET_VAL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic [4:0] alu_select,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_op_enable,
  input  logic [7:0] alu_out,
  input  logic       alu_flag_zero,
  input  logic       alu_flag_carry,
  output logic [7:0] pc,
  output logic       flag_z,
  output logic       flag_c,
  output logic       halted,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] byte0_q, byte0_d;
  logic       flag_z_q, flag_z_d;
  logic       flag_c_q, flag_c_d;
  logic       mem_req_q, mem_req_d;
  logic       alu_op_enable_q, alu_op_enable_d;
  logic [4:0] alu_select_q, alu_select_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;

  logic [7:0] rf_rdata_a;
  logic [7:0] rf_rdata_b;
  logic       rf_we;

  // Port A reads rd from the latched byte0; port B reads rs straight off the
  // arriving byte1 so operands can be registered on the F1 ack edge.
  reg_file_4x8 #(
    .NREGS (NREGS)
  ) u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (rd_of(byte0_q)),
    .rdata_a (rf_rdata_a),
    .raddr_b (rs_of(mem_rdata)),
    .rdata_b (rf_rdata_b),
    .we      (rf_we),
    .waddr   (rd_of(byte0_q)),
    .wdata   (alu_out)
  );

  assign rf_we = (state_q == S_WB);

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    byte0_d         = byte0_q;
    flag_z_d        = flag_z_q;
    flag_c_d        = flag_c_q;
    alu_op_enable_d = 1'b0;
    alu_select_d    = alu_select_q;
    alu_a_d         = alu_a_q;
    alu_b_d         = alu_b_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_F0;
      end
      S_F0: begin
        if (mem_ack) begin
          byte0_d = mem_rdata;
          pc_d    = pc_q + 8'd1;
          state_d = (opcode_of(mem_rdata) == HALT_OP) ? S_HALT : S_F1;
        end
      end
      S_F1: begin
        if (mem_ack) begin
          // byte1 is consumed here directly into the operand B register.
          pc_d            = pc_q + 8'd1;
          state_d         = S_EX;
          alu_op_enable_d = 1'b1;
          alu_select_d    = opcode_of(byte0_q);
          alu_a_d         = rf_rdata_a;
          alu_b_d         = imm_of(byte0_q) ? mem_rdata : rf_rdata_b;
        end
      end
      S_EX: begin
        state_d = S_WB;
      end
      S_WB: begin
        flag_z_d = alu_flag_zero;
        flag_c_d = alu_flag_carry;
        state_d  = S_F0;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    mem_req_d = (state_d == S_F0) || (state_d == S_F1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      pc_q            <= PC_RESET;
      byte0_q         <= 8'h00;
      flag_z_q        <= 1'b0;
      flag_c_q        <= 1'b0;
      mem_req_q       <= 1'b0;
      alu_op_enable_q <= 1'b0;
      alu_select_q    <= 5'd0;
      alu_a_q         <= 8'h00;
      alu_b_q         <= 8'h00;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      byte0_q         <= byte0_d;
      flag_z_q        <= flag_z_d;
      flag_c_q        <= flag_c_d;
      mem_req_q       <= mem_req_d;
      alu_op_enable_q <= alu_op_enable_d;
      alu_select_q    <= alu_select_d;
      alu_a_q         <= alu_a_d;
      alu_b_q         <= alu_b_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_addr      = pc_q;
  assign pc            = pc_q;
  assign alu_op_enable = alu_op_enable_q;
  assign alu_select    = alu_select_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign flag_z        = flag_z_q;
  assign flag_c        = flag_c_q;
  assign halted        = (state_q == S_HALT);
  assign busy          = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

// File: tb/tb_alu_issue_controller.sv
// tb/tb_alu_issue_controller.sv - scoreboard bench for alu_issue_controller
module tb_alu_issue_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [4:0] alu_select;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_op_enable;
  logic [7:0] alu_out = 8'h00;
  logic       alu_flag_zero = 1'b0;
  logic       alu_flag_carry = 1'b0;
  logic [7:0] pc;
  logic       flag_z;
  logic       flag_c;
  logic       halted;
  logic       busy;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [256];
  int          stall_tab [256];
  int          stall_cnt = 0;
  logic [20:0] exp_q [$];
  logic        prev_wait = 1'b0;
  logic [7:0]  prev_addr = 8'h00;

  always #5 clk = ~clk;

  alu_issue_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .alu_select     (alu_select),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_op_enable  (alu_op_enable),
    .alu_out        (alu_out),
    .alu_flag_zero  (alu_flag_zero),
    .alu_flag_carry (alu_flag_carry),
    .pc             (pc),
    .flag_z         (flag_z),
    .flag_c         (flag_c),
    .halted         (halted),
    .busy           (busy)
  );

  // Memory responder: ack after stall_tab[addr] wait cycles, data same cycle.
  assign mem_ack   = mem_req && (stall_cnt >= stall_tab[mem_addr]);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!mem_req || mem_ack) stall_cnt <= 0;
    else                     stall_cnt <= stall_cnt + 1;
  end

  // ALU model: out = a + b (+ 8'hCB when select==1); carry = any bit above 7.
  always @(posedge clk) begin : alu_model
    logic [9:0] s;
    if (alu_op_enable) begin
      s = {2'b00, alu_a} + {2'b00, alu_b} + ((alu_select == 5'd1) ? 10'h0CB : 10'h000);
      alu_out        <= s[7:0];
      alu_flag_carry <= |s[9:8];
      alu_flag_zero  <= (s[7:0] == 8'h00);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every EX cycle must match the next expected issue.
  always @(negedge clk) begin
    if (rst_n && alu_op_enable) begin
      if (exp_q.size() == 0) begin
        check("ex_unexpected", 32'({alu_select, alu_a, alu_b}), 32'h1FFFFF);
      end else begin
        check("ex_issue", 32'({alu_select, alu_a, alu_b}), 32'(exp_q.pop_front()));
      end
    end
  end

  // A request left unacked must be held with the same address next cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) check("stall_hold", 32'({mem_req, mem_addr}), 32'({1'b1, prev_addr}));
      prev_wait = mem_req && !mem_ack;
      prev_addr = mem_addr;
    end
  end

  task automatic push_ex(input logic [4:0] sel, input logic [7:0] a, input logic [7:0] b);
    exp_q.push_back({sel, a, b});
  endtask

  // kind: 0 fetch of addr, 1 EX cycle, 2 halted, 3 any request
  task automatic wait_for(input int kind, input logic [7:0] addr, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      case (kind)
        0: ok = mem_req && (mem_addr == addr);
        1: ok = alu_op_enable;
        2: ok = halted;
        default: ok = mem_req;
      endcase
      if (ok) break;
    end
    check({"timeout_", name}, 32'(ok), 32'd1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'hF8;
      stall_tab[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clear_mem();

    // Reset / idle
    repeat (2) @(negedge clk);
    check("rst_outputs", 32'({mem_req, alu_op_enable, alu_select, alu_a, alu_b}), 32'd0);
    check("rst_status", 32'({halted, busy, flag_z, flag_c, pc}), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle", 32'({mem_req, pc, busy}), 32'd0);
    end

    // Program A: immediate op, register op with stalls, flags, halt
    mem[0]  = 8'h0B; mem[1]  = 8'h14; push_ex(5'd1, 8'h00, 8'h14); // R1 = DF
    mem[2]  = 8'h03; mem[3]  = 8'h00; push_ex(5'd0, 8'hDF, 8'h00); // R1 read back
    mem[4]  = 8'h05; mem[5]  = 8'hCB; push_ex(5'd0, 8'h00, 8'hCB); // R2 = CB
    mem[6]  = 8'h14; mem[7]  = 8'h80; push_ex(5'd2, 8'hCB, 8'hCB); // R2 = 96, C=1
    mem[8]  = 8'h07; mem[9]  = 8'h00; push_ex(5'd0, 8'h00, 8'h00); // R3 = 0, Z=1
    mem[10] = 8'h05; mem[11] = 8'h00; push_ex(5'd0, 8'h96, 8'h00); // R2 read back
    mem[12] = 8'hF8;
    for (int i = 4; i < 8; i++) stall_tab[i] = 3;

    pulse_start();
    check("a_f0", 32'({mem_req, mem_addr, busy}), 32'({1'b1, 8'h00, 1'b1}));
    @(negedge clk);
    check("a_f1", 32'({mem_req, mem_addr, pc}), 32'({1'b1, 8'h01, 8'h01}));
    @(negedge clk);
    check("a_ex", 32'({alu_op_enable, mem_req, pc}), 32'({1'b1, 1'b0, 8'h02}));
    @(negedge clk);
    check("a_wb", 32'({alu_op_enable, mem_req, alu_select, alu_b}), 32'({1'b0, 1'b0, 5'd1, 8'h14}));
    @(negedge clk);
    check("a_4cyc", 32'({mem_req, mem_addr}), 32'({1'b1, 8'h02}));

    wait_for(0, 8'h08, "fetch8");
    check("flags_carry", 32'({flag_z, flag_c}), 32'({1'b0, 1'b1}));
    wait_for(0, 8'h0A, "fetch10");
    check("flags_zero", 32'({flag_z, flag_c}), 32'({1'b1, 1'b0}));
    wait_for(2, 8'h00, "halt_a");
    check("a_halt", 32'({halted, busy, mem_req, pc}), 32'({1'b1, 1'b0, 1'b0, 8'h0D}));

    // Program B: one instruction then HALT; start afterwards is ignored
    do_reset();
    clear_mem();
    mem[0] = 8'h0B; mem[1] = 8'h14; push_ex(5'd1, 8'h00, 8'h14);
    mem[2] = 8'hF8;
    pulse_start();
    wait_for(2, 8'h00, "halt_b");
    check("b_halt", 32'({halted, mem_req, pc}), 32'({1'b1, 1'b0, 8'h03}));
    pulse_start();
    repeat (5) @(negedge clk);
    check("b_halt_sticky", 32'({halted, busy, mem_req, pc}), 32'({1'b1, 1'b0, 1'b0, 8'h03}));

    // Program C: run through address FF, then reset mid-EX
    do_reset();
    for (int i = 0; i < 256; i++) begin
      mem[i] = (i % 2 == 0) ? 8'h01 : 8'h00;
      stall_tab[i] = 0;
    end
    for (int i = 0; i < 127; i++) push_ex(5'd0, 8'h00, 8'h00);
    mem[254] = 8'h0F; mem[255] = 8'h05; push_ex(5'd1, 8'h00, 8'h05); // R3 = D0
    push_ex(5'd1, 8'hD0, 8'h05); // wrapped instruction would make R3 = A0
    pulse_start();
    wait_for(0, 8'h10, "fetch10h");
    mem[0] = 8'h0F; mem[1] = 8'h05;
    wait_for(0, 8'hFF, "fetchFF");
    wait_for(1, 8'h00, "ex_FE");
    check("pc_wrap", 32'(pc), 32'h00);
    wait_for(3, 8'h00, "refetch");
    check("wrap_fetch", 32'({mem_req, mem_addr}), 32'({1'b1, 8'h00}));
    wait_for(1, 8'h00, "ex_wrapped");
    #2 rst_n = 1'b0;
    #1 check("rst_mid_ex", 32'({alu_op_enable, busy, mem_req, halted, pc}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_flags", 32'({flag_z, flag_c, busy}), 32'd0);

    // Program D: R3 must read back as cleared (no writeback of the aborted op)
    clear_mem();
    mem[0] = 8'h0F; mem[1] = 8'h00; push_ex(5'd1, 8'h00, 8'h00);
    mem[2] = 8'hF8;
    pulse_start();
    wait_for(2, 8'h00, "halt_d");
    check("d_halt", 32'({halted, pc}), 32'({1'b1, 8'h03}));

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_controller.md
Name: alu_issue_controller

Overview:
- Control stage directly upstream of the 8-bit ALU. Fetches 2-byte instructions from program memory over a req/ack handshake and reads operands from an internal 4x8 register file.
- Drives the ALU's select, operand and op_enable inputs, then writes the ALU result and flags back into the register file and a flag register.
- Turns the free-running ALU into a sequenced execute unit of the 8-bit CPU.

Parameters:
- NREGS, 4, number of general registers (fixed at 4; register index width 2).
- HALT_OP, 5'b11111, opcode that stops execution.
- PC_RESET, 8'h00, program counter value after reset.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; leaves IDLE
- mem_req  output  1  program memory read request
- mem_addr  output  8  program memory byte address (= pc)
- mem_ack  input  1  memory response; mem_rdata valid in the same cycle
- mem_rdata  input  8  instruction byte
- alu_select  output  5  ALU operation select (= opcode)
- alu_a  output  8  ALU operand A
- alu_b  output  8  ALU operand B
- alu_op_enable  output  1  ALU evaluate strobe
- alu_out  input  8  ALU result, valid the cycle after alu_op_enable
- alu_flag_zero  input  1  ALU zero flag, same timing as alu_out
- alu_flag_carry  input  1  ALU carry flag, same timing as alu_out
- pc  output  8  current program counter
- flag_z  output  1  registered zero flag
- flag_c  output  1  registered carry flag
- halted  output  1  high in HALT state
- busy  output  1  high in any state except IDLE and HALT

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; pc=PC_RESET; all registers 0; flag_z=flag_c=0.
  - mem_req=0, alu_op_enable=0, alu_select/alu_a/alu_b=0, halted=0, busy=0.
  - Reset mid-instruction abandons it; no partial writeback.
- Instruction format:
  - byte0={opcode[4:0], rd[1:0], imm}.
  - byte1 = immediate when imm=1; otherwise byte1[7:6]=rs and byte1[5:0] is ignored.
- States:
  - IDLE: on start go to F0; otherwise hold.
  - F0: mem_req=1, mem_addr=pc. On mem_ack, latch byte0 and pc<=pc+1 (8-bit wrap, FF->00).
    - opcode==HALT_OP: go to HALT.
    - Otherwise go to F1.
    - No ack: stay, holding req and addr stable.
  - F1: same handshake; on mem_ack latch byte1, pc<=pc+1, go to EX.
  - EX (1 cycle):
    - alu_op_enable=1, alu_select=opcode, alu_a=R[rd].
    - alu_b = imm ? byte1 : R[rs].
    - Go to WB.
  - WB (1 cycle):
    - alu_op_enable=0; alu_select/a/b hold EX values.
    - R[rd]<=alu_out; flag_z<=alu_flag_zero; flag_c<=alu_flag_carry.
    - Go to F0.
  - HALT: halted=1, mem_req=0. The HALT instruction consumes 1 byte. Exits only via rst_n; start is ignored.
- Timing: with ack in the request cycle an instruction takes 4 cycles (F0, F1, EX, WB).
- Handshake rules:
  - mem_req deasserts in the cycle after the ack.
  - mem_req is low in EX, WB, IDLE and HALT.
  - mem_ack outside F0/F1 is ignored.
- Register hazard: rd==rs reads the pre-writeback value. A write in WB is visible to the next instruction's EX.
- start while busy is ignored.

Decomposition:
- Shared package (cpu_pkg):
  - State encoding: IDLE, F0, F1, EX, WB, HALT.
  - Opcode width 5; HALT_OP; register index width 2; instruction field bit positions.
- Sub-module reg_file_4x8:
  - Two combinational read ports, one synchronous write port.
  - Asynchronous active-low clear.

Test Plan:
- Reset/idle: hold rst_n=0, then release with no start.
  - Required: mem_req=0, pc=00, busy=0 for 10 cycles.
- Immediate op: memory {00001_01_1, 8'h14}; ALU model returns alu_out=8'hDF, carry=0, zero=0.
  - Required in EX: alu_select=1, alu_a=00, alu_b=14, alu_op_enable=1.
  - Required after WB: R1=DF, pc=02, 4 cycles total.
- Register op with a stalled memory: first instruction loads R2=CB via immediate; second is {00010_10_0, 2'b10,6'b0}; mem_ack delayed 3 cycles on each byte.
  - Required: mem_req/mem_addr stable during the stall.
  - Required in EX: alu_a=alu_b=CB.
  - Required after WB: R2 = model result; flag_c and flag_z latched from the model.
- HALT: after one valid instruction, byte 8'hF8.
  - Required: halted=1, pc=03, mem_req=0.
  - A further start pulse must not change state.
- PC wrap: preload memory so execution runs through address FF.
  - Required: pc 8'hFF -> 8'h00 and the next fetch uses mem_addr=00.
- Async reset mid-EX: assert rst_n=0 between clock edges while in EX.
  - Required: alu_op_enable=0 immediately, no register writeback, state IDLE, registers 0.
